// File: rtl/kfps2kb_pkg.sv
// kfps2kb_pkg: shared capture-state enum and keycode constants for the keycode FIFO.
package kfps2kb_pkg;
  typedef enum logic {CAP_IDLE, CAP_ACK} cap_state_e;
  localparam logic [7:0] KB_CODE_OVERRUN  = 8'hFF;
  localparam logic [7:0] KB_CODE_SELFTEST = 8'hAA;
  localparam logic [7:0] KB_CODE_NONE     = 8'h00;
endpackage

// File: rtl/kfps2kb_fifo_ram.sv
// kfps2kb_fifo_ram: DEPTHx8 keycode storage, synchronous write, asynchronous read.
module kfps2kb_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clock)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/kfps2kb_keycode_fifo.sv
// kfps2kb_keycode_fifo: captures PS/2 controller keycodes into a FIFO and
// replays them to the PC-XT side with the same irq/keycode/clear handshake.
module kfps2kb_keycode_fifo
  import kfps2kb_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter int         ADDR_W       = 4,
  parameter logic [7:0] OVERRUN_CODE = KB_CODE_OVERRUN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            kb_irq,
  input  logic [7:0]      kb_keycode,
  output logic            kb_clear,
  input  logic            flush,
  output logic            irq,
  output logic [7:0]      keycode,
  input  logic            clear_keycode,
  output logic [ADDR_W:0] count,
  output logic            overrun
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  cap_state_e state_q, state_d;
  logic kb_clear_q, kb_clear_d, irq_q, irq_d, overrun_q, overrun_d, clr_q;
  logic [7:0] keycode_q, keycode_d, rdata;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic push, pop, wr_en;
  assign push  = !flush && state_q == CAP_IDLE && kb_irq;
  assign pop   = !flush && clear_keycode && !clr_q && count_q != '0;
  assign wr_en = push && count_q != FULL;
  kfps2kb_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock  (clock),
    .we_i   (wr_en),
    .waddr_i(wptr_q),
    .wdata_i(count_q == LAST ? OVERRUN_CODE : kb_keycode),
    .raddr_i(rptr_q),
    .rdata_o(rdata)
  );
  always_comb begin
    state_d    = state_q;
    kb_clear_d = 1'b0;
    if (flush) begin
      state_d    = CAP_IDLE;
      kb_clear_d = 1'b1;
    end else if (state_q == CAP_ACK) begin
      state_d = CAP_IDLE;
    end else if (kb_irq) begin
      state_d    = CAP_ACK;
      kb_clear_d = 1'b1;
    end
  end
  // Presentation follows the pre-update count, giving one cycle from push to irq.
  always_comb begin
    wptr_d    = flush ? '0 : wptr_q + ADDR_W'(wr_en);
    rptr_d    = flush ? '0 : rptr_q + ADDR_W'(pop);
    count_d   = flush ? '0 : count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
    overrun_d = !flush && (overrun_q || (push && count_q >= LAST));
    irq_d     = !flush && !clear_keycode && count_q != '0;
    keycode_d = irq_d ? rdata : KB_CODE_NONE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q    <= CAP_IDLE;
      kb_clear_q <= 1'b0;
      irq_q      <= 1'b0;
      keycode_q  <= KB_CODE_NONE;
      overrun_q  <= 1'b0;
      clr_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      kb_clear_q <= kb_clear_d;
      irq_q      <= irq_d;
      keycode_q  <= keycode_d;
      overrun_q  <= overrun_d;
      clr_q      <= clear_keycode;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  assign kb_clear = kb_clear_q;
  assign irq      = irq_q;
  assign keycode  = keycode_q;
  assign count    = count_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_kfps2kb_keycode_fifo.sv
// tb_kfps2kb_keycode_fifo: table-driven plus directed sequences for the keycode FIFO.
module tb_kfps2kb_keycode_fifo;
  logic clock = 1'b0, reset_n = 1'b0, kb_irq = 1'b0, flush = 1'b0, clear_keycode = 1'b0;
  logic [7:0] kb_keycode = 8'h00;
  logic kb_clear, irq, overrun;
  logic [7:0] keycode;
  logic [4:0] count;
  int total = 0, bad = 0, n_clr = 0, snap;

  typedef struct {
    logic       kb_irq;
    logic [7:0] code;
    logic       clr;
    logic       e_irq;
    logic [7:0] e_key;
    logic [4:0] e_cnt;
    logic       e_kbclr;
  } vec_t;
  vec_t tbl [17];

  kfps2kb_keycode_fifo dut (
    .clock(clock), .reset_n(reset_n), .kb_irq(kb_irq), .kb_keycode(kb_keycode),
    .kb_clear(kb_clear), .flush(flush), .irq(irq), .keycode(keycode),
    .clear_keycode(clear_keycode), .count(count), .overrun(overrun)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (kb_clear === 1'b1) n_clr++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] code);
    kb_irq = 1'b1;
    kb_keycode = code;
    tick();
    tick();
    kb_irq = 1'b0;
  endtask

  task automatic ack();
    clear_keycode = 1'b1;
    tick();
    clear_keycode = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    chk("flush_kbclr", kb_clear, 1);
    flush = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0]  = '{1, 8'h1E, 0, 0, 8'h00, 1, 1};
    tbl[1]  = '{1, 8'h1E, 0, 1, 8'h1E, 1, 0};
    tbl[2]  = '{0, 8'h1E, 0, 1, 8'h1E, 1, 0};
    tbl[3]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0};
    tbl[4]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[5]  = '{1, 8'h10, 0, 0, 8'h00, 1, 1};
    tbl[6]  = '{1, 8'h10, 0, 1, 8'h10, 1, 0};
    tbl[7]  = '{1, 8'h90, 0, 1, 8'h10, 2, 1};
    tbl[8]  = '{1, 8'h90, 0, 1, 8'h10, 2, 0};
    tbl[9]  = '{1, 8'h11, 0, 1, 8'h10, 3, 1};
    tbl[10] = '{1, 8'h11, 0, 1, 8'h10, 3, 0};
    tbl[11] = '{0, 8'h00, 1, 0, 8'h00, 2, 0};
    tbl[12] = '{0, 8'h00, 0, 1, 8'h90, 2, 0};
    tbl[13] = '{0, 8'h00, 1, 0, 8'h00, 1, 0};
    tbl[14] = '{0, 8'h00, 0, 1, 8'h11, 1, 0};
    tbl[15] = '{0, 8'h00, 1, 0, 8'h00, 0, 0};
    tbl[16] = '{0, 8'h00, 0, 0, 8'h00, 0, 0};

    #1;
    chk("rst_irq", irq, 0);
    chk("rst_key", keycode, 0);
    chk("rst_cnt", count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_kbclr", kb_clear, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      kb_irq = tbl[i].kb_irq;
      kb_keycode = tbl[i].code;
      clear_keycode = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
      chk($sformatf("vec%0d_key", i), keycode, tbl[i].e_key);
      chk($sformatf("vec%0d_cnt", i), count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_kbclr", i), kb_clear, tbl[i].e_kbclr);
      chk($sformatf("vec%0d_ovr", i), overrun, 0);
    end
    kb_irq = 1'b0;
    clear_keycode = 1'b0;

    do_flush();
    send(8'h21);
    send(8'h22);
    send(8'h23);
    tick();
    chk("held_cnt0", count, 3);
    clear_keycode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_irq", irq, 0);
    end
    chk("held_cnt", count, 2);
    clear_keycode = 1'b0;
    tick();
    chk("held_rel_irq", irq, 1);
    chk("held_rel_key", keycode, 8'h22);

    do_flush();
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    tick();
    chk("sim_cnt0", count, 5);
    chk("sim_head0", keycode, 8'h31);
    kb_irq = 1'b1;
    kb_keycode = 8'h2A;
    clear_keycode = 1'b1;
    tick();
    chk("sim_cnt1", count, 5);
    chk("sim_kbclr", kb_clear, 1);
    tick();
    chk("sim_cnt2", count, 5);
    kb_irq = 1'b0;
    clear_keycode = 1'b0;
    tick();
    chk("sim_head1", keycode, 8'h32);
    ack();
    chk("sim_head2", keycode, 8'h33);
    ack();
    chk("sim_head3", keycode, 8'h34);
    ack();
    chk("sim_head4", keycode, 8'h35);
    ack();
    chk("sim_tail", keycode, 8'h2A);
    chk("sim_cnt3", count, 1);

    do_flush();
    snap = n_clr;
    for (int i = 0; i < 20; i++) send(8'h40 + 8'(i));
    tick();
    chk("ovr_pulses", n_clr - snap, 20);
    chk("ovr_cnt", count, 16);
    chk("ovr_flag", overrun, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_irq%0d", i), irq, 1);
      chk($sformatf("ovr_ent%0d", i), keycode, i < 15 ? 8'h40 + 8'(i) : 8'hFF);
      ack();
    end
    chk("ovr_empty_irq", irq, 0);
    chk("ovr_empty_cnt", count, 0);
    chk("ovr_sticky", overrun, 1);

    for (int i = 0; i < 7; i++) send(8'h60 + 8'(i));
    tick();
    chk("fl_cnt0", count, 7);
    kb_irq = 1'b1;
    kb_keycode = 8'h50;
    flush = 1'b1;
    tick();
    chk("fl_cnt", count, 0);
    chk("fl_irq", irq, 0);
    chk("fl_key", keycode, 0);
    chk("fl_ovr", overrun, 0);
    chk("fl_kbclr", kb_clear, 1);
    flush = 1'b0;
    kb_irq = 1'b0;
    tick();
    chk("fl_cnt1", count, 0);
    send(8'hAA);
    tick();
    chk("fl_aa_irq", irq, 1);
    chk("fl_aa_key", keycode, 8'hAA);
    chk("fl_aa_cnt", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kfps2kb_keycode_fifo.md
Name: kfps2kb_keycode_fifo

Overview:
Sits directly downstream of the PS/2 keyboard controller. It captures each XT (set-1) keycode the controller raises on irq and releases the controller at once with a one-cycle clear pulse. Codes are buffered in a small FIFO and presented to the PC-XT system side (PPI port A / IRQ1) one at a time with the same irq/keycode/clear handshake. This keeps keystrokes from being lost or collapsed to 0xFF while the BIOS is slow to acknowledge.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two and at least 4.
ADDR_W, 4, log2(DEPTH).
OVERRUN_CODE, 8'hFF, code stored in the last free slot when the FIFO overruns.

Ports:
clock  input  1  system clock; all logic is on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
kb_irq  input  1  keycode-valid level from the keyboard controller.
kb_keycode  input  8  set-1 keycode from the keyboard controller.
kb_clear  output  1  one-cycle pulse to the controller's clear_keycode input.
flush  input  1  synchronous flush; driven by the same strobe as reset_keyboard.
irq  output  1  keycode available to the system (feeds IRQ1).
keycode  output  8  head-of-FIFO code presented to PPI port A.
clear_keycode  input  1  system acknowledge level (PPI port B bit 7).
count  output  ADDR_W+1  current number of FIFO entries.
overrun  output  1  sticky flag; set on any dropped or replaced code.

Behaviour:
- Reset (reset_n=0, asynchronous): irq=0, keycode=8'h00, kb_clear=0, count=0, overrun=0, pointers=0, capture FSM=CAP_IDLE, clear-edge register=0.
- Capture FSM, two states:
  - CAP_IDLE: if kb_irq=1, push kb_keycode, register kb_clear=1 and go to CAP_ACK.
  - CAP_ACK: kb_irq is ignored, because the upstream irq is still high in this cycle. kb_clear=0 next cycle, then return to CAP_IDLE.
  - Result: exactly one push per upstream code. Minimum spacing between upstream codes is 2 cycles.
- Push rules:
  - count < DEPTH-1: write kb_keycode.
  - count == DEPTH-1: write OVERRUN_CODE instead of kb_keycode and set overrun.
  - count == DEPTH: drop the code, set overrun, and still pulse kb_clear.
- Pop and presentation:
  - The output registers show the head entry: irq=1 and keycode=head whenever the FIFO is non-empty and clear_keycode=0.
  - While clear_keycode=1, the next registered state is irq=0, keycode=8'h00, matching the controller's level semantics.
  - A rising edge of clear_keycode (registered edge detect) pops the head entry exactly once. Holding clear_keycode high pops nothing further.
  - After clear_keycode falls, the next entry (if any) appears on the following edge.
- Latency: kb_irq high while the FIFO is empty at edge N produces the push at edge N and irq=1 with keycode valid after edge N+1.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. Full-state checks use count before the pop.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits and ranges 0..DEPTH.
- flush (highest priority after reset):
  - Clears pointers, count, irq, keycode and overrun.
  - Forces the FSM to CAP_IDLE and drives kb_clear=1 for that cycle, so any pending upstream code is discarded.
  - A controller 0xAA self-test code arriving after flush is captured normally.
- flush and a clear_keycode edge together: flush wins and no pop is counted.
- Storage contents are not reset; only pointers are.

Decomposition:
- Shared package kfps2kb_pkg holds:
  - the capture-state enum {CAP_IDLE, CAP_ACK};
  - constants KB_CODE_OVERRUN=8'hFF, KB_CODE_SELFTEST=8'hAA, KB_CODE_NONE=8'h00.
- Sub-module kfps2kb_fifo_ram: DEPTH×8 storage with a synchronous write port and an asynchronous read port.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
1. Single code: kb_irq=1 with 8'h1E for 2 cycles -> kb_clear pulses once one cycle later; irq=1 with keycode=8'h1E after edge N+1; count=1. A clear_keycode 0→1 pulse -> irq=0, keycode=00, count=0.
2. Burst: push 8'h10, 8'h90, 8'h11 before any ack -> three ack cycles return 10, 90, 11 in order; irq drops after the third ack; count reaches 0.
3. Overrun: 20 pushes with DEPTH=16 and no ack -> entries 0..14 hold the pushed codes, entry 15=8'hFF, the remaining 4 are dropped; overrun=1; kb_clear pulses 20 times.
4. Held ack: clear_keycode held high for 10 cycles with count=3 -> only one pop (count=2); irq stays 0 until release, then keycode shows the second entry.
5. Simultaneous: with count=5, push 8'h2A in the same cycle as a clear_keycode rising edge -> count stays 5; the head advances; 8'h2A lands at the tail.
6. Flush mid-operation: count=7, kb_irq=1 and flush=1 in the same cycle -> count=0, irq=0, overrun=0, kb_clear=1; a later 8'hAA push reaches keycode=8'hAA.
